alu_sequencer: RTL and testbench

Sequential ALU front end that accepts one operation request at a time over a valid/ready handshake. It executes ADD, SUB and bitwise operations in one cycle on a shared add/sub datapath. MUL is run as an unsigned shift-add over DATA_W cycles on that same adder, so no array multiplier is needed. The registered result, carry and error flag are returned over a second valid/ready handshake; the block sits between the instruction/control logic and the arithmetic datapath.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_sequencer_add_sub_w.sv | 31 +++
 rtl/alu_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, controller state encoding and sizing constants for alu_sequencer.
package alu_seq_pkg;
  localparam int DEF_DATA_W = 16;
  // One shared-adder pass per multiplier bit.
  localparam int MUL_ITERS  = DEF_DATA_W;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MUL_ITER = 2'd2,
    ST_DONE     = 2'd3
  } state_t;
endpackage

// File: rtl/alu_sequencer_add_sub_w.sv
// Ripple add/sub shared by single-cycle ops and the MUL iterations; combinational.
// mode=1 inverts b and injects carry-in, so the result is a-b with carry=1 meaning no borrow.
module add_sub_w #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  output logic [DATA_W-1:0] sum,
  output logic              carry_out,
  output logic              overflow
);
  logic [DATA_W-1:0] w_b;
  logic              w_chain;
  logic              w_cin_msb;

  assign w_b = b ^ {DATA_W{mode}};

  always_comb begin
    sum       = '0;
    w_chain   = mode;
    w_cin_msb = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == DATA_W - 1) w_cin_msb = w_chain;
      sum[i]  = a[i] ^ w_b[i] ^ w_chain;
      w_chain = (a[i] & w_b[i]) | (w_chain & (a[i] ^ w_b[i]));
    end
    carry_out = w_chain;
    overflow  = w_chain ^ w_cin_msb;
  end
endmodule

// File: rtl/alu_sequencer.sv
// Sequential ALU: one request at a time; 2 cycles to response (MUL: DATA_W+1), shift-add MUL.
// Accepts only in IDLE; response held in DONE until rsp_ready, then back to IDLE next cycle.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = MUL_ITERS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            opcode,
  input  logic [DATA_W-1:0]     dataA,
  input  logic [DATA_W-1:0]     dataB,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic                  carry,
  output logic                  err
);
  localparam int CNT_W = $clog2(DATA_W);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_op;
  logic [DATA_W-1:0]     r_a, r_b;
  logic [2*DATA_W-1:0]   r_prod, r_result, w_prod_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry, r_err;
  logic [DATA_W-1:0]     w_add_a, w_add_b, w_sum;
  logic                  w_mode, w_co, w_ov, w_accept, w_last;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // MUL_ITER adds B into the product's upper half when the current multiplier bit is set.
  always_comb begin
    w_add_a = r_a;
    w_add_b = r_b;
    w_mode  = 1'b0;
    if (r_state == ST_MUL_ITER) begin
      w_add_a = r_prod[2*DATA_W-1:DATA_W];
      w_add_b = r_prod[0] ? r_b : '0;
    end else begin
      w_mode = (r_op == OP_SUB);
    end
  end

  add_sub_w #(.DATA_W(DATA_W)) u_add_sub (
    .a         (w_add_a),
    .b         (w_add_b),
    .mode      (w_mode),
    .sum       (w_sum),
    .carry_out (w_co),
    .overflow  (w_ov)
  );

  assign w_prod_nxt = {w_co, w_sum, r_prod[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (opcode == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
      end
      ST_EXEC:     w_state_nxt = ST_DONE;
      ST_MUL_ITER: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= opcode;
        r_a    <= dataA;
        r_b    <= dataB;
        r_prod <= {{DATA_W{1'b0}}, dataA};
        r_cnt  <= '0;
      end
      if (r_state == ST_EXEC) begin
        r_carry <= 1'b0;
        r_err   <= 1'b0;
        unique case (r_op)
          OP_ADD, OP_SUB: begin
            r_result <= {{DATA_W{1'b0}}, w_sum};
            r_carry  <= w_co;
            r_err    <= w_ov;
          end
          OP_AND:  r_result <= {{DATA_W{1'b0}}, r_a & r_b};
          OP_OR:   r_result <= {{DATA_W{1'b0}}, r_a | r_b};
          OP_XOR:  r_result <= {{DATA_W{1'b0}}, r_a ^ r_b};
          default: begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        endcase
      end
      if (r_state == ST_MUL_ITER) begin
        r_prod <= w_prod_nxt;
        // Counter parks on its last value; the next accept clears it.
        if (w_last) begin
          r_result <= w_prod_nxt;
          r_carry  <= 1'b0;
          r_err    <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign err    = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vectors, random ops vs. an arithmetic model,
// backpressure, operand-change isolation and reset during a multiply.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  opcode;
  logic [15:0] dataA;
  logic [15:0] dataB;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        carry;
  logic        err;

  int checks;
  int failures;

  alu_sequencer #(.DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .opcode    (opcode),
    .dataA     (dataA),
    .dataB     (dataB),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .carry     (carry),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] r, output logic c, output logic e);
    logic [16:0] s;
    r = 32'h0; c = 1'b0; e = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = {16'h0, s[15:0]}; c = s[16];
        e = (a[15] == b[15]) && (s[15] != a[15]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = {16'h0, s[15:0]}; c = s[16];
        e = (a[15] != b[15]) && (s[15] != a[15]);
      end
      OP_MUL: r = {16'h0, a} * {16'h0, b};
      OP_AND: r = {16'h0, a & b};
      OP_OR:  r = {16'h0, a | b};
      OP_XOR: r = {16'h0, a ^ b};
      default: e = 1'b1;
    endcase
  endtask

  // Issue one request, verify latency, hold the response for `hold` cycles, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input string tag);
    logic [31:0] er;
    logic        ec, ee;
    int          k;
    int          exp_lat;
    model(op, a, b, er, ec, ee);
    exp_lat = (op == OP_MUL) ? MUL_ITERS + 1 : 2;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b exp=1", tag, req_ready);
    end
    req_valid = 1'b1; opcode = op; dataA = a; dataB = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    opcode = 4'($urandom); dataA = 16'($urandom); dataB = 16'($urandom);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!rsp_valid) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_ready cycle=%0d got=%b exp=0", tag, k, req_ready);
        end
      end
    end while (rsp_valid !== 1'b1 && k < 40);
    checks++;
    if (k != exp_lat || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, k, exp_lat);
      return;
    end
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) rsp_ready = 1'b1;
      checks++;
      if (result !== er || carry !== ec || err !== ee || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s response hold=%0d got res=%h c=%b e=%b rdy=%b vld=%b exp res=%h c=%b e=%b rdy=0 vld=1",
                 tag, i, result, carry, err, req_ready, rsp_valid, er, ec, ee);
      end
      if (i < hold) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s turnaround got rdy=%b vld=%b exp rdy=1 vld=0", tag, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    opcode = 4'h0; dataA = 16'h0; dataB = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || result !== 32'h0 || carry !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h c=%b e=%b exp rdy=1 vld=0 res=0 c=0 e=0",
               req_ready, rsp_valid, result, carry, err);
    end
  endtask

  task automatic test_directed;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 0, "add_ovf");
    run_op(OP_SUB, 16'h0005, 16'h0007, 0, "sub_borrow");
    run_op(OP_SUB, 16'h0007, 16'h0005, 1, "sub_noborrow");
    run_op(OP_MUL, 16'h000F, 16'h0007, 0, "mul_small");
    run_op(OP_AND, 16'hF0F0, 16'h3C3C, 0, "and");
    run_op(OP_OR,  16'hF0F0, 16'h3C3C, 0, "or");
    run_op(OP_XOR, 16'hF0F0, 16'h3C3C, 0, "xor");
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 0, "add_carry");
  endtask

  task automatic test_backpressure;
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 5, "mul_max_bp");
  endtask

  task automatic test_illegal;
    run_op(4'hF, 16'h1234, 16'h0000, 0, "illegal_f");
    run_op(4'h6, 16'hABCD, 16'h1111, 2, "illegal_6");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      run_op(4'($urandom_range(0, 5)), 16'($urandom), 16'($urandom), 0, "b2b");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), $urandom_range(0, 3), "rand");
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; opcode = OP_MUL; dataA = 16'h1234; dataB = 16'h5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || result !== 32'h0 || carry !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear got vld=%b res=%h c=%b e=%b exp vld=0 res=0 c=0 e=0",
               rsp_valid, result, carry, err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got=%b exp=1", req_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midreset_no_rsp got=%0d exp=0", seen);
    end
    run_op(OP_ADD, 16'h0002, 16'h0003, 0, "post_reset_add");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stuck handshake still reaches a verdict.
  initial begin
    #400000;
    $display("FAIL global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
